ps2_receptor: RTL and testbench
===============================

Name: ps2_receptor

Overview:
- PS/2 keyboard front end; feeds the Recep command interpreter.
- Synchronises and filters the PS/2 clock and data lines and deserialises 11-bit device-to-host frames.
- Validates parity and stop bit, and removes break (F0) and extended (E0) prefix traffic.
- Presents each accepted make code on Dato with a one-cycle flag pulse.

Parameters:
FILTER_LEN, 8, number of consecutive equal system-clock samples of ps2c required to change the filtered level (range 2..16)
TIMEOUT_CYCLES, 100000, system clocks without a falling edge after which a partial frame is abandoned (1 ms at 100 MHz)
DROP_BREAK, 1, 1 = suppress F0 and the byte after it; 0 = deliver every valid byte, F0 included

Ports:
CLK  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
ps2c  input  1  raw PS/2 clock pin, asynchronous
ps2d  input  1  raw PS/2 data pin, asynchronous
Dato  output  8  last accepted scan code; held until the next accepted byte
flag  output  1  one-cycle pulse: Dato is new this cycle
err_paridad  output  1  one-cycle pulse: frame rejected (parity or stop bit)
err_trama  output  1  one-cycle pulse: frame abandoned on timeout

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high; port name is reset.
- Synchroniser: ps2c and ps2d each pass through 2 FFs.
- Filter: FILTER_LEN-bit shift register on synced ps2c.
  - Filtered level goes to 0 when all bits are 0, to 1 when all bits are 1, otherwise holds.
  - tick = 1-cycle pulse on a filtered 1->0 transition.
- ps2d sampling: synced ps2d is sampled on tick.
- FSM states:
  - IDLE: on tick with ps2d=0 (start bit), go to DATOS with bit count = 0. On tick with ps2d=1, stay in IDLE (spurious edge, no error).
  - DATOS: each tick shifts ps2d into an LSB-first register and increments the count. After the 9th tick (8 data bits + parity), go to PARADA.
  - PARADA: on tick, sample the stop bit and go to ENTREGA.
  - ENTREGA: one cycle, then return to IDLE.
- Validation in ENTREGA: the frame is valid iff stop = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
- Valid frame, byte routing (in this priority):
  - byte = E0: discard, no flag.
  - byte = F0 and DROP_BREAK = 1: set break_pend, no flag.
  - break_pend = 1: clear break_pend and discard the byte, no flag.
  - otherwise: Dato <= byte and flag = 1 in the cycle after ENTREGA.
- Invalid frame: err_paridad = 1 for one cycle. Dato, flag and break_pend are unchanged.
- Latency: the flag pulse occurs exactly 2 CLK cycles after the tick that sampled the stop bit.
- Timeout:
  - A cycle counter clears on every tick and counts while in DATOS or PARADA.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, discard the partial data, pulse err_trama for 1 cycle.
  - break_pend is kept on timeout. The counter is held at 0 in IDLE.
- Reset values:
  - Dato = 00, flag = 0, err_paridad = 0, err_trama = 0, state = IDLE.
  - break_pend = 0, bit count = 0, timeout counter = 0.
  - Filter shift register all 1s and filtered level = 1, so no tick fires on release.
- Reset mid-frame: the partial frame is dropped with no flag and no error pulse. The next start bit is decoded normally.
- Simultaneous events:
  - A tick arriving in ENTREGA is ignored; the PS/2 bit period of at least 60 µs makes this unreachable in practice.
  - Timeout and tick in the same cycle: the tick wins and the counter clears.
- Output timing: flag and the error pulses are mutually exclusive, and each is a pulse of exactly one cycle.
- DROP_BREAK = 0: F0 is delivered as an ordinary byte, and break_pend stays 0. E0 is still discarded.

Test Plan:
1. Send frame 0x43 (start 0, data LSB first, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> exactly one flag pulse, Dato = 43 exactly 2 CLK after the stop-bit tick; Dato held at 43 afterwards.
2. Send 0x5A, then F0, then 0x5A -> exactly one flag (Dato = 5A); Dato stays 5A; break_pend = 0 at the end. Repeat with DROP_BREAK = 0 -> three flags: 5A, F0, 5A.
3. Send 0x16 with the parity bit inverted -> err_paridad pulses once, no flag, Dato keeps its previous value. Then send a good 0x3E -> flag with Dato = 3E.
4. Send a start bit + 4 data bits, then hold ps2c high for TIMEOUT_CYCLES+10 CLK -> err_trama pulses once, state back to IDLE. A following full 0x1C frame -> flag with Dato = 1C.
5. Inject 3-cycle low glitches on ps2c with FILTER_LEN = 8 while idle, and a 3-cycle glitch mid-frame -> no ticks from the glitches, no flag and no errors. The later valid 0x45 frame decodes with Dato = 45.
6. Assert reset for 1 cycle after bit 5 of a 0x4D frame -> all outputs 0, no flag. Then send E0 followed by 0x2E -> single flag with Dato = 2E.

Source files
------------

// File: rtl/ps2_receptor.sv
// PS/2 keyboard receiver front end.
// Synchronises and glitch-filters the PS/2 clock and data pins, deserialises 11-bit
// device-to-host frames, checks odd parity and the stop bit, strips E0 prefixes and
// (optionally) F0 break sequences, and presents accepted make codes.
//
// Ports:
//   CLK          system clock
//   reset        synchronous active-high reset
//   ps2c, ps2d   raw asynchronous PS/2 clock and data pins
//   Dato         last accepted scan code, held until the next one
//   flag         one-cycle pulse, Dato is new this cycle
//   err_paridad  one-cycle pulse, frame rejected (parity or stop bit)
//   err_trama    one-cycle pulse, partial frame abandoned on timeout
module ps2_receptor #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          DROP_BREAK     = 1'b1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] Dato,
  output logic       flag,
  output logic       err_paridad,
  output logic       err_trama
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StDatos, StParada, StEntrega} state_e;

  // Two-flop synchronisers
  logic c_meta_q, c_sync_q, d_meta_q, d_sync_q;

  // Clock filter
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  level_q, level_d;
  logic                  tick;

  // Frame state
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    shreg_q, shreg_d;
  logic          stop_q, stop_d;
  logic [TW-1:0] to_q, to_d;
  logic          break_pend_q, break_pend_d;
  logic [7:0]    dato_q, dato_d;
  logic          flag_q, flag_d;
  logic          errp_q, errp_d;
  logic          errt_q, errt_d;

  logic          frame_ok;
  logic          to_hit;
  logic [7:0]    rx_byte;

  always_comb begin
    filt_d  = {filt_q[FILTER_LEN-2:0], c_sync_q};
    level_d = level_q;
    if (filt_q == '0) begin
      level_d = 1'b0;
    end else if (filt_q == '1) begin
      level_d = 1'b1;
    end
  end

  // Tick is high in the cycle the filtered level is about to fall.
  assign tick = level_q & ~level_d;

  // Data bits 0..7 end up in shreg_q[7:0], parity in shreg_q[8].
  assign rx_byte  = shreg_q[7:0];
  assign frame_ok = stop_q & (^shreg_q);
  assign to_hit   = (to_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    stop_d       = stop_q;
    to_d         = to_q;
    break_pend_d = break_pend_q;
    dato_d       = dato_q;
    flag_d       = 1'b0;
    errp_d       = 1'b0;
    errt_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        to_d = '0;
        if (tick && !d_sync_q) begin
          state_d = StDatos;
          cnt_d   = '0;
        end
      end

      StDatos: begin
        if (tick) begin
          shreg_d = {d_sync_q, shreg_q[8:1]};
          cnt_d   = cnt_q + 4'd1;
          to_d    = '0;
          if (cnt_q == 4'd8) begin
            state_d = StParada;
          end
        end else if (to_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
          shreg_d = '0;
          to_d    = '0;
          errt_d  = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      StParada: begin
        if (tick) begin
          stop_d  = d_sync_q;
          to_d    = '0;
          state_d = StEntrega;
        end else if (to_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
          shreg_d = '0;
          to_d    = '0;
          errt_d  = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      StEntrega: begin
        // Any tick here is ignored; PS/2 bit periods make it unreachable.
        state_d = StIdle;
        to_d    = '0;
        cnt_d   = '0;
        if (!frame_ok) begin
          errp_d = 1'b1;
        end else if (rx_byte == 8'hE0) begin
          // Extended prefix: dropped.
        end else if (DROP_BREAK && (rx_byte == 8'hF0)) begin
          break_pend_d = 1'b1;
        end else if (break_pend_q) begin
          break_pend_d = 1'b0;
        end else begin
          dato_d = rx_byte;
          flag_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      c_meta_q     <= 1'b1;
      c_sync_q     <= 1'b1;
      d_meta_q     <= 1'b1;
      d_sync_q     <= 1'b1;
      filt_q       <= '1;
      level_q      <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      stop_q       <= 1'b0;
      to_q         <= '0;
      break_pend_q <= 1'b0;
      dato_q       <= 8'h00;
      flag_q       <= 1'b0;
      errp_q       <= 1'b0;
      errt_q       <= 1'b0;
    end else begin
      c_meta_q     <= ps2c;
      c_sync_q     <= c_meta_q;
      d_meta_q     <= ps2d;
      d_sync_q     <= d_meta_q;
      filt_q       <= filt_d;
      level_q      <= level_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      stop_q       <= stop_d;
      to_q         <= to_d;
      break_pend_q <= break_pend_d;
      dato_q       <= dato_d;
      flag_q       <= flag_d;
      errp_q       <= errp_d;
      errt_q       <= errt_d;
    end
  end

  assign Dato        = dato_q;
  assign flag        = flag_q;
  assign err_paridad = errp_q;
  assign err_trama   = errt_q;

endmodule

// File: tb/tb_ps2_receptor.sv
// Bench for ps2_receptor: two instances (break suppression on and off) share one PS/2
// stimulus stream. Stimulus pushes expected events into per-instance queues; a monitor
// pops and compares whenever an instance pulses flag or an error output.
module tb_ps2_receptor;

  localparam int unsigned F  = 8;
  localparam int unsigned TO = 400;

  localparam logic [1:0] KFlag  = 2'd0;
  localparam logic [1:0] KPar   = 2'd1;
  localparam logic [1:0] KTrama = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] dato_w [2];
  logic       flg [2];
  logic       ep  [2];
  logic       et  [2];

  logic [31:0] cyc = 0;
  logic        rst_seen = 1'b0;
  int          total = 0;
  int          bad = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  bit         brk [2];
  logic [7:0] exp_dato [2];

  // Index 1: DROP_BREAK = 1, index 0: DROP_BREAK = 0
  ps2_receptor #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .DROP_BREAK(1'b1)) dut1 (
    .CLK(CLK), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .Dato(dato_w[1]),
    .flag(flg[1]), .err_paridad(ep[1]), .err_trama(et[1])
  );
  ps2_receptor #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .DROP_BREAK(1'b0)) dut0 (
    .CLK(CLK), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .Dato(dato_w[0]),
    .flag(flg[0]), .err_paridad(ep[0]), .err_trama(et[0])
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input int i, input logic [1:0] kind, input logic [7:0] data,
                      input logic [31:0] c);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Reference behaviour for one complete frame, applied to both instances.
  // Flag/parity outputs appear 2 sync + F filter + 2 cycles after the stop-bit fall.
  task automatic model_frame(input logic [7:0] b, input bit good, input logic [31:0] fall);
    logic [31:0] at;
    at = fall + F + 4;
    for (int i = 0; i < 2; i++) begin
      if (!good) push(i, KPar, 8'h00, at);
      else if (b == 8'hE0) begin end
      else if (i == 1 && b == 8'hF0) brk[i] = 1'b1;
      else if (brk[i]) brk[i] = 1'b0;
      else push(i, KFlag, b, at);
    end
  endtask

  // Sends the first nbits bits of a frame (11 = complete). A low glitch of 3 cycles
  // is inserted during the high phase after bit index glitch_at (negative = none).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      ps2d = bits[k];
      wait_cyc($urandom_range(30, 60));
      ps2c = 1'b0;
      if (k == 10) model_frame(b, !bad_par, cyc);
      wait_cyc($urandom_range(30, 60));
      ps2c = 1'b1;
      if (k == glitch_at) begin
        wait_cyc(12);
        ps2c = 1'b0;
        wait_cyc(3);
        ps2c = 1'b1;
      end
    end
    ps2d = 1'b1;
    if (nbits < 11 && nbits > 0) begin
      push(0, KTrama, 8'h00, 0);
      push(1, KTrama, 8'h00, 0);
      wait_cyc(TO + 10 + 20);
    end
    wait_cyc(40);
  endtask

  task automatic glitch_idle();
    wait_cyc(20);
    ps2c = 1'b0;
    wait_cyc(3);
    ps2c = 1'b1;
    wait_cyc(20);
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [1:0]  got_kind;
    int          n;
    int          qs;
    exp_dato[0] = 8'h00;
    exp_dato[1] = 8'h00;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (rst_seen) exp_dato[i] = 8'h00;
        n = int'(flg[i]) + int'(ep[i]) + int'(et[i]);
        if (n != 0) begin
          chk(n == 1, "exclusive_pulses", n, 1);
          qs = (i == 0) ? q0.size() : q1.size();
          chk(qs != 0, "unexpected_event", {flg[i], ep[i], et[i]}, 0);
          if (qs != 0) begin
            if (i == 0) e = q0.pop_front();
            else e = q1.pop_front();
            got_kind = flg[i] ? KFlag : (ep[i] ? KPar : KTrama);
            chk(got_kind == e.kind, "event_kind", got_kind, e.kind);
            if (e.kind != KTrama) chk(cyc == e.cyc, "event_latency", cyc, e.cyc);
            if (e.kind == KFlag) begin
              chk(dato_w[i] === e.data, "dato_on_flag", dato_w[i], e.data);
              exp_dato[i] = e.data;
            end
          end
        end else begin
          chk(dato_w[i] === exp_dato[i], "dato_hold", dato_w[i], exp_dato[i]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] b;
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    brk[0] = 1'b0;
    brk[1] = 1'b0;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 2; i++) begin
      chk(dato_w[i] == 8'h00 && !flg[i] && !ep[i] && !et[i], "reset_state",
          {dato_w[i], flg[i], ep[i], et[i]}, 0);
    end

    send_frame(8'h43, 1'b0, 11, -1);

    send_frame(8'h5A, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h5A, 1'b0, 11, -1);
    chk(dut1.break_pend_q == 1'b0, "break_pend_cleared", dut1.break_pend_q, 0);
    chk(dut0.break_pend_q == 1'b0, "break_pend_nodrop", dut0.break_pend_q, 0);

    send_frame(8'h16, 1'b1, 11, -1);
    send_frame(8'h3E, 1'b0, 11, -1);

    send_frame(8'h99, 1'b0, 5, -1);
    send_frame(8'h1C, 1'b0, 11, -1);
    // Break pending survives a timeout.
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h77, 1'b0, 5, -1);
    send_frame(8'h22, 1'b0, 11, -1);
    send_frame(8'h1C, 1'b0, 11, -1);

    repeat (3) glitch_idle();
    send_frame(8'h45, 1'b0, 11, 3);

    // Reset after data bit 5 of 0x4D (start + bits 0..5 sent).
    send_frame(8'h4D, 1'b0, 0, -1);
    begin
      logic [10:0] bits;
      bits = {1'b1, ~^8'h4D, 8'h4D, 1'b0};
      for (int k = 0; k < 7; k++) begin
        ps2d = bits[k];
        wait_cyc(40);
        ps2c = 1'b0;
        wait_cyc(40);
        ps2c = 1'b1;
      end
      ps2d = 1'b1;
      wait_cyc(20);
      reset = 1'b1;
      wait_cyc(1);
      reset = 1'b0;
      brk[0] = 1'b0;
      brk[1] = 1'b0;
      wait_cyc(1);
      for (int i = 0; i < 2; i++) begin
        chk(dato_w[i] == 8'h00 && !flg[i] && !ep[i] && !et[i], "midframe_reset",
            {dato_w[i], flg[i], ep[i], et[i]}, 0);
      end
      wait_cyc(TO + 20);
    end
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'h2E, 1'b0, 11, -1);

    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hF0;
        1:       b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      send_frame(b, $urandom_range(0, 5) == 0, 11,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
    end

    for (int w = 0; w < 1000 && (q0.size() != 0 || q1.size() != 0); w++) wait_cyc(1);
    chk(q0.size() == 0, "drain_nodrop", q0.size(), 0);
    chk(q1.size() == 0, "drain_drop", q1.size(), 0);
    chk(dut1.break_pend_q == brk[1], "break_pend_final", dut1.break_pend_q, brk[1]);
    chk(dut0.break_pend_q == brk[0], "break_pend_final0", dut0.break_pend_q, brk[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
